// File: rtl/risc8_dma.sv
// risc8_dma: cycle-stealing DMA engine and data-RAM port arbiter.
// The core always owns the RAM port when it strobes; the DMA copies (or fills)
// a block of up to 255 bytes using only idle bus cycles.
// Optional feature macro: RISC8_DMA_FILL_EN (enables CTRL.FILL constant-fill mode).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_addr/ren/wen/wdata     core data bus request
//   ram_addr/ren/wen/wdata     muxed RAM port (combinational mux)
//   ram_rdata                  RAM read data, one cycle after ram_ren
//   io_addr/ren/wen/wdata      I/O register access
//   io_hit                     combinational register-window decode
//   io_rdata                   registered I/O read data
//   busy, irq                  transfer in progress, DONE & IRQ_EN
module risc8_dma #(
    parameter logic [6:0] IO_BASE = 7'h50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    input  logic [7:0]  cpu_wdata,
    output logic [15:0] ram_addr,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    input  logic [6:0]  io_addr,
    input  logic        io_ren,
    input  logic        io_wen,
    input  logic [7:0]  io_wdata,
    output logic        io_hit,
    output logic [7:0]  io_rdata,
    output logic        busy,
    output logic        irq
);

`ifdef RISC8_DMA_FILL_EN
    localparam bit FillEn = 1'b1;
`else
    localparam bit FillEn = 1'b0;
`endif

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_CAP, ST_WR} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d, dst_q, dst_d;
    logic [DW-1:0] len_q, len_d, buf_q, buf_d, io_rdata_q, io_rdata_d;
    logic          irq_en_q, irq_en_d, fill_q, fill_d, done_q, done_d;
    logic          busy_q, irq_q;

    logic [6:0]    io_off;
    logic          in_win, wr_hit, rd_hit, ctrl_wr;
    logic          idle, abort_now, start_now, dma_free, dma_ren, dma_wen;
    logic          unused_wdata;

    // Register window decode; the >= test keeps the offset subtraction from wrapping.
    assign io_off    = io_addr - IO_BASE;
    assign in_win    = (io_addr >= IO_BASE) && (io_off < 7'd6);
    assign io_hit    = (io_ren | io_wen) & in_win;
    assign wr_hit    = io_wen & in_win;
    assign rd_hit    = io_ren & in_win;
    assign ctrl_wr   = wr_hit && (io_off == 7'd5);

    assign idle      = (state_q == ST_IDLE);
    assign abort_now = ctrl_wr & io_wdata[1];
    assign start_now = ctrl_wr & io_wdata[0] & ~io_wdata[1] & idle;

    // DMA strobes only in free cycles; an abort or reset in flight blocks them immediately.
    assign dma_free  = ~(cpu_ren | cpu_wen) & ~abort_now & ~reset;
    assign dma_ren   = (state_q == ST_RD) & dma_free;
    assign dma_wen   = (state_q == ST_WR) & dma_free;

    assign unused_wdata = ^{io_wdata[7], io_wdata[5:4]};

    // Next-state: register writes, then transfer sequencing.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        buf_d      = buf_q;
        irq_en_d   = irq_en_q;
        fill_d     = fill_q;
        done_d     = done_q;
        io_rdata_d = io_rdata_q;

        if (wr_hit) begin
            case (io_off)
                7'd0: if (idle) src_d[7:0]  = io_wdata;
                7'd1: if (idle) src_d[15:8] = io_wdata;
                7'd2: if (idle) dst_d[7:0]  = io_wdata;
                7'd3: if (idle) dst_d[15:8] = io_wdata;
                7'd4: if (idle) len_d       = io_wdata;
                7'd5: begin
                    irq_en_d = io_wdata[2];
                    // Mode is frozen while a transfer runs.
                    if (idle) fill_d = FillEn & io_wdata[3];
                    if (io_wdata[6]) done_d = 1'b0;
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start_now) begin
                    if (len_q == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        state_d = fill_d ? ST_WR : ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (dma_ren) state_d = ST_CAP;
            end
            ST_CAP: begin
                buf_d   = ram_rdata;
                state_d = ST_WR;
            end
            ST_WR: begin
                if (dma_wen) begin
                    dst_d = dst_q + 16'd1;
                    if (!fill_q) src_d = src_q + 16'd1;
                    len_d = len_q - 8'd1;
                    if (len_q == 8'd1) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = fill_q ? ST_WR : ST_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_now) state_d = ST_IDLE;

        if (rd_hit) begin
            case (io_off)
                7'd0:    io_rdata_d = src_q[7:0];
                7'd1:    io_rdata_d = src_q[15:8];
                7'd2:    io_rdata_d = dst_q[7:0];
                7'd3:    io_rdata_d = dst_q[15:8];
                7'd4:    io_rdata_d = len_q;
                default: io_rdata_d = {1'b0, done_q, 2'b00, fill_q, irq_en_q, 1'b0, ~idle};
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            buf_q      <= '0;
            irq_en_q   <= 1'b0;
            fill_q     <= 1'b0;
            done_q     <= 1'b0;
            io_rdata_q <= '0;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            buf_q      <= buf_d;
            irq_en_q   <= irq_en_d;
            fill_q     <= fill_d;
            done_q     <= done_d;
            io_rdata_q <= io_rdata_d;
            busy_q     <= (state_d != ST_IDLE);
            irq_q      <= done_d & irq_en_d;
        end
    end

    // RAM port mux: core pass-through unless the DMA owns this free cycle.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_ren   = cpu_ren;
        ram_wen   = cpu_wen;
        ram_wdata = cpu_wdata;
        if (dma_ren) begin
            ram_addr = src_q;
            ram_ren  = 1'b1;
        end else if (dma_wen) begin
            ram_addr  = dst_q;
            ram_wen   = 1'b1;
            ram_wdata = fill_q ? src_q[7:0] : buf_q;
        end
    end

    assign busy     = busy_q;
    assign irq      = irq_q;
    assign io_rdata = io_rdata_q;

endmodule

// File: tb/tb_risc8_dma.sv
// Self-checking bench for risc8_dma: RAM model, scoreboard of expected DMA
// reads/writes, directed register-level scenarios.
module tb_risc8_dma;

    localparam logic [6:0] IO_BASE = 7'h50;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_ren, cpu_wen;
    logic [7:0]  cpu_wdata;
    logic [15:0] ram_addr;
    logic        ram_ren, ram_wen;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic [6:0]  io_addr;
    logic        io_ren, io_wen;
    logic [7:0]  io_wdata;
    logic        io_hit;
    logic [7:0]  io_rdata;
    logic        busy, irq;

    int tests = 0;
    int fails = 0;
    int dma_rd_cnt = 0;
    int dma_wr_cnt = 0;

    logic [15:0] exp_rd [$];
    logic [23:0] exp_wr [$];

    logic [7:0] mem [0:65535];
    bit         wr_valid [0:65535];

    always #5 clk = ~clk;

    risc8_dma #(.IO_BASE(IO_BASE)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_wdata(cpu_wdata),
        .ram_addr(ram_addr), .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .io_addr(io_addr), .io_ren(io_ren), .io_wen(io_wen), .io_wdata(io_wdata),
        .io_hit(io_hit), .io_rdata(io_rdata), .busy(busy), .irq(irq)
    );

    // Background pattern for never-written RAM locations.
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return wr_valid[a] ? mem[a] : pat(a);
    endfunction

    // Single-port RAM with registered read data.
    always @(posedge clk) begin
        if (ram_wen) begin
            mem[ram_addr]      <= ram_wdata;
            wr_valid[ram_addr] <= 1'b1;
        end
        if (ram_ren) ram_rdata <= mem_rd(ram_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: core pass-through and DMA strobes against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_ren || cpu_wen) begin
                check("core_passthrough", {ram_addr, ram_ren, ram_wen, ram_wdata},
                      {cpu_addr, cpu_ren, cpu_wen, cpu_wdata});
            end else begin
                if (ram_ren) begin
                    dma_rd_cnt++;
                    check("dma_rd_expected", 32'(exp_rd.size() != 0), 1);
                    if (exp_rd.size() != 0) check("dma_rd_addr", ram_addr, exp_rd.pop_front());
                end
                if (ram_wen) begin
                    dma_wr_cnt++;
                    check("dma_wr_expected", 32'(exp_wr.size() != 0), 1);
                    if (exp_wr.size() != 0) check("dma_wr_addr_data", {ram_addr, ram_wdata}, exp_wr.pop_front());
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [2:0] off, input logic [7:0] d);
        io_addr  = IO_BASE + 7'(off);
        io_wdata = d;
        io_wen   = 1'b1;
        tick();
        io_wen   = 1'b0;
    endtask

    task automatic reg_check(input string tag, input logic [2:0] off, input logic [7:0] exp);
        io_addr = IO_BASE + 7'(off);
        io_ren  = 1'b1;
        @(negedge clk);
        check("io_hit", io_hit, 1);
        tick();
        io_ren = 1'b0;
        check(tag, io_rdata, exp);
    endtask

    task automatic setup(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] len);
        io_write(3'd0, src[7:0]);
        io_write(3'd1, src[15:8]);
        io_write(3'd2, dst[7:0]);
        io_write(3'd3, dst[15:8]);
        io_write(3'd4, len);
    endtask

    task automatic push_copy(input logic [15:0] src, input logic [15:0] dst, input int len);
        for (int i = 0; i < len; i++) begin
            exp_rd.push_back(src + 16'(i));
            exp_wr.push_back({dst + 16'(i), pat(src + 16'(i))});
        end
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (busy && cycles < budget);
        check("busy_timeout", busy, 0);
    endtask

    task automatic check_copy(input logic [15:0] src, input logic [15:0] dst, input int len);
        for (int i = 0; i < len; i++)
            check("ram_copy_data", mem_rd(dst + 16'(i)), pat(src + 16'(i)));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int cyc, rd0, wr0;
        reset = 1'b1;
        cpu_addr = '0; cpu_ren = 0; cpu_wen = 0; cpu_wdata = '0;
        io_addr = '0; io_ren = 0; io_wen = 0; io_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_outputs", {busy, irq, io_rdata, ram_ren, ram_wen}, 0);
        for (int i = 0; i < 6; i++) reg_check("rst_reg", 3'(i), 8'h00);

        // Window boundaries
        io_addr = IO_BASE + 7'd6; io_ren = 1'b1;
        @(negedge clk); check("io_hit_above", io_hit, 0);
        io_addr = IO_BASE - 7'd1;
        @(negedge clk); check("io_hit_below", io_hit, 0);
        tick(); io_ren = 1'b0;

        // Basic copy, idle core
        setup(16'h0100, 16'h0200, 8'd4);
        push_copy(16'h0100, 16'h0200, 4);
        rd0 = dma_rd_cnt; wr0 = dma_wr_cnt;
        io_write(3'd5, 8'h01);
        wait_idle(100, cyc);
        check("copy_cycles", cyc, 12);
        check("copy_rd_count", dma_rd_cnt - rd0, 4);
        check("copy_wr_count", dma_wr_cnt - wr0, 4);
        check_copy(16'h0100, 16'h0200, 4);
        reg_check("copy_ctrl", 3'd5, 8'h40);
        reg_check("copy_len", 3'd4, 8'h00);
        reg_check("copy_src_l", 3'd0, 8'h04);
        reg_check("copy_src_h", 3'd1, 8'h01);
        reg_check("copy_dst_l", 3'd2, 8'h04);
        reg_check("copy_dst_h", 3'd3, 8'h02);
        tick();
        check("io_rdata_hold", io_rdata, 8'h02);

        // Copy with core reading every other cycle
        setup(16'h0110, 16'h0210, 8'd4);
        push_copy(16'h0110, 16'h0210, 4);
        io_write(3'd5, 8'h01);
        cyc = 0;
        do begin
            cpu_ren  = (cyc % 2 == 0);
            cpu_addr = 16'h0800 + 16'(cyc);
            tick();
            cyc++;
        end while (busy && cyc < 100);
        cpu_ren = 1'b0;
        check("stall_busy_timeout", busy, 0);
        check("stall_cycles", cyc, 16);
        check_copy(16'h0110, 16'h0210, 4);
        reg_check("stall_ctrl", 3'd5, 8'h40);

        // Address wrap; register writes while busy are ignored
        setup(16'hFFFE, 16'h0300, 8'd3);
        push_copy(16'hFFFE, 16'h0300, 3);
        io_write(3'd5, 8'h01);
        io_write(3'd0, 8'h77);
        wait_idle(100, cyc);
        check_copy(16'hFFFE, 16'h0300, 3);
        reg_check("wrap_src_l", 3'd0, 8'h01);
        reg_check("wrap_src_h", 3'd1, 8'h00);
        check("wrap_queue_empty", exp_wr.size(), 0);

        // Interrupt on completion, cleared by DONE write-1-to-clear
        setup(16'h0120, 16'h0220, 8'd2);
        push_copy(16'h0120, 16'h0220, 2);
        io_write(3'd5, 8'h05);
        reg_check("irq_ctrl_busy", 3'd5, 8'h05);
        check("irq_low_while_busy", irq, 0);
        wait_idle(100, cyc);
        check("irq_raised", irq, 1);
        reg_check("irq_ctrl_done", 3'd5, 8'h44);
        io_write(3'd5, 8'h40);
        check("irq_cleared", irq, 0);
        reg_check("irq_ctrl_clr", 3'd5, 8'h00);

        // START with LEN=0
        io_write(3'd4, 8'h00);
        io_write(3'd5, 8'h01);
        check("len0_busy", busy, 0);
        reg_check("len0_ctrl", 3'd5, 8'h40);
        io_write(3'd5, 8'h40);

        // ABORT after the first write
        setup(16'h0130, 16'h0230, 8'd5);
        push_copy(16'h0130, 16'h0230, 5);
        wr0 = dma_wr_cnt;
        io_write(3'd5, 8'h01);
        repeat (3) tick();
        check("abort_first_wr", dma_wr_cnt - wr0, 1);
        rd0 = dma_rd_cnt;
        io_write(3'd5, 8'h03);
        exp_rd.delete(); exp_wr.delete();
        check("abort_busy", busy, 0);
        repeat (10) tick();
        check("abort_no_rd", dma_rd_cnt - rd0, 0);
        check("abort_no_wr", dma_wr_cnt - wr0, 1);
        reg_check("abort_ctrl", 3'd5, 8'h00);
        reg_check("abort_src_l", 3'd0, 8'h31);
        reg_check("abort_dst_l", 3'd2, 8'h31);
        io_write(3'd5, 8'h03);
        tick();
        check("start_abort_idle", busy, 0);
        reg_check("abort_len", 3'd4, 8'h04);

`ifdef RISC8_DMA_FILL_EN
        // Constant fill
        setup(16'h00A5, 16'h0400, 8'd8);
        for (int i = 0; i < 8; i++) exp_wr.push_back({16'h0400 + 16'(i), 8'hA5});
        rd0 = dma_rd_cnt;
        io_write(3'd5, 8'h09);
        wait_idle(100, cyc);
        check("fill_cycles", cyc, 8);
        check("fill_no_rd", dma_rd_cnt - rd0, 0);
        for (int i = 0; i < 8; i++) check("fill_data", mem_rd(16'h0400 + 16'(i)), 8'hA5);
        reg_check("fill_ctrl", 3'd5, 8'h48);
        reg_check("fill_src_l", 3'd0, 8'hA5);
`else
        // FILL bit has no effect without the fill feature
        setup(16'h0150, 16'h0250, 8'd2);
        push_copy(16'h0150, 16'h0250, 2);
        rd0 = dma_rd_cnt;
        io_write(3'd5, 8'h09);
        wait_idle(100, cyc);
        check("nofill_cycles", cyc, 6);
        check("nofill_rd", dma_rd_cnt - rd0, 2);
        check_copy(16'h0150, 16'h0250, 2);
        reg_check("nofill_ctrl", 3'd5, 8'h40);
`endif

        // Reset mid-transfer
        reg_check("pre_rst_len", 3'd4, 8'h00);
        setup(16'h0140, 16'h0240, 8'd5);
        reg_check("pre_rst_len5", 3'd4, 8'h05);
        push_copy(16'h0140, 16'h0240, 5);
        wr0 = dma_wr_cnt;
        io_write(3'd5, 8'h05);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("midrst_outputs", {busy, irq, io_rdata, ram_ren, ram_wen}, 0);
        reset = 1'b0;
        exp_rd.delete(); exp_wr.delete();
        repeat (8) tick();
        check("midrst_wr_count", dma_wr_cnt - wr0, 1);
        reg_check("midrst_ctrl", 3'd5, 8'h00);
        reg_check("midrst_len", 3'd4, 8'h00);
        reg_check("midrst_src_h", 3'd1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
